// File: rtl/jal_redirect_stage.sv
// Decode-side stage: registers fetch output, resolves JAL targets and holds a redirect to fetch
// until acknowledged, squashing wrong-path input meanwhile. Optional counters: JAL_REDIRECT_PERF_EN.
module jal_redirect_stage #(
  parameter int unsigned XLEN       = 32,
  parameter logic [6:0]  JAL_OPCODE = 7'b1101111
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            out_is_jal,
  output logic [XLEN-1:0] out_link,
  output logic            out_misaligned,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_target,
  input  logic            redirect_ack
`ifdef JAL_REDIRECT_PERF_EN
  ,
  output logic [31:0]     perf_redirects,
  output logic [31:0]     perf_squashed
`endif
);

  typedef enum logic {
    StRun,
    StWaitAck
  } state_e;

  state_e state_q, state_d;

  logic            out_valid_q;
  logic [XLEN-1:0] out_pc_q;
  logic [31:0]     out_instr_q;
  logic            out_is_jal_q;
  logic [XLEN-1:0] out_link_q;
  logic            out_misaligned_q;
  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_target_q;

  // J-type field split and address arithmetic on the incoming instruction
  logic [20:0]     imm21;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] in_target;
  logic [XLEN-1:0] in_link;
  logic            in_is_jal;

  assign imm21     = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign imm_sext  = {{(XLEN-21){imm21[20]}}, imm21};
  assign in_target = in_pc + imm_sext;
  assign in_link   = in_pc + XLEN'(4);
  assign in_is_jal = (in_instr[6:0] == JAL_OPCODE);

  logic ready;
  logic load;
  logic start_redirect;
  logic clear_redirect;
  logic squash;
  logic consume;

  assign consume = out_valid_q && out_ready;

  always_comb begin
    state_d        = state_q;
    ready          = 1'b1;
    load           = 1'b0;
    start_redirect = 1'b0;
    clear_redirect = 1'b0;
    squash         = 1'b0;
    unique case (state_q)
      StRun: begin
        ready = !out_valid_q || out_ready;
        if (in_valid && ready) begin
          load = 1'b1;
          if (in_is_jal) begin
            start_redirect = 1'b1;
            state_d        = StWaitAck;
          end
        end
      end
      StWaitAck: begin
        // Everything fetch hands over here is wrong-path, including the ack cycle.
        ready  = 1'b1;
        squash = in_valid;
        if (redirect_ack) begin
          clear_redirect = 1'b1;
          state_d        = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q      <= 1'b0;
      out_pc_q         <= '0;
      out_instr_q      <= '0;
      out_is_jal_q     <= 1'b0;
      out_link_q       <= '0;
      out_misaligned_q <= 1'b0;
    end else if (load) begin
      out_valid_q      <= 1'b1;
      out_pc_q         <= in_pc;
      out_instr_q      <= in_instr;
      out_is_jal_q     <= in_is_jal;
      out_link_q       <= in_link;
      out_misaligned_q <= in_is_jal && in_target[1];
    end else if (consume) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid_q  <= 1'b0;
      redirect_target_q <= '0;
    end else if (start_redirect) begin
      redirect_valid_q  <= 1'b1;
      redirect_target_q <= in_target;
    end else if (clear_redirect) begin
      redirect_valid_q  <= 1'b0;
    end
  end

`ifdef JAL_REDIRECT_PERF_EN
  logic [31:0] perf_redirects_q;
  logic [31:0] perf_squashed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_redirects_q <= '0;
      perf_squashed_q  <= '0;
    end else begin
      if (start_redirect) perf_redirects_q <= perf_redirects_q + 32'd1;
      if (squash)         perf_squashed_q  <= perf_squashed_q + 32'd1;
    end
  end

  assign perf_redirects = perf_redirects_q;
  assign perf_squashed  = perf_squashed_q;
`endif

  assign in_ready        = ready;
  assign out_valid       = out_valid_q;
  assign out_pc          = out_pc_q;
  assign out_instr       = out_instr_q;
  assign out_is_jal      = out_is_jal_q;
  assign out_link        = out_link_q;
  assign out_misaligned  = out_misaligned_q;
  assign redirect_valid  = redirect_valid_q;
  assign redirect_target = redirect_target_q;

endmodule

// File: tb/tb_jal_redirect_stage.sv
// Self-checking bench for jal_redirect_stage: directed scenarios then random traffic against
// a cycle-level behavioural model of the stage.
module tb_jal_redirect_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_is_jal;
  logic [31:0] out_link;
  logic        out_misaligned;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        redirect_ack;
`ifdef JAL_REDIRECT_PERF_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_squashed;
`endif

  jal_redirect_stage #(
    .XLEN      (32),
    .JAL_OPCODE(7'b1101111)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_instr       (in_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_is_jal     (out_is_jal),
    .out_link       (out_link),
    .out_misaligned (out_misaligned),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .redirect_ack   (redirect_ack)
`ifdef JAL_REDIRECT_PERF_EN
    ,
    .perf_redirects (perf_redirects),
    .perf_squashed  (perf_squashed)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model of what the stage should be presenting
  bit          m_ov;
  logic [31:0] m_pc, m_instr, m_link;
  bit          m_jal, m_mis;
  bit          m_rv;
  logic [31:0] m_tgt;
  logic [31:0] m_perf_red, m_perf_sq;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Offset built from the J-type fields as a signed byte distance.
  function automatic logic [31:0] jal_target(input logic [31:0] pc, input logic [31:0] ins);
    logic [31:0] off;
    off = ins[31] ? 32'hFFF0_0000 : 32'h0;
    off = off + ({24'h0, ins[19:12]} << 12);
    off = off + ({31'h0, ins[20]} << 11);
    off = off + ({22'h0, ins[30:21]} << 1);
    return pc + off;
  endfunction

  task automatic model_reset();
    m_ov = 0; m_pc = 0; m_instr = 0; m_link = 0; m_jal = 0; m_mis = 0;
    m_rv = 0; m_tgt = 0; m_perf_red = 0; m_perf_sq = 0;
  endtask

  task automatic check_outputs();
    check_eq("out_valid", out_valid, m_ov);
    check_eq("redirect_valid", redirect_valid, m_rv);
    if (m_ov) begin
      check_eq("out_pc", out_pc, m_pc);
      check_eq("out_instr", out_instr, m_instr);
      check_eq("out_is_jal", out_is_jal, m_jal);
      check_eq("out_link", out_link, m_link);
      check_eq("out_misaligned", out_misaligned, m_mis);
    end
    if (m_rv) check_eq("redirect_target", redirect_target, m_tgt);
`ifdef JAL_REDIRECT_PERF_EN
    check_eq("perf_redirects", perf_redirects, m_perf_red);
    check_eq("perf_squashed", perf_squashed, m_perf_sq);
`endif
  endtask

  task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                      input logic ordy, input logic ack);
    bit exp_rdy, hs, consume, is_jal;
    in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy; redirect_ack = ack;
    #1;
    exp_rdy = m_rv ? 1'b1 : (!m_ov || ordy);
    check_eq("in_ready", in_ready, exp_rdy);
    hs      = iv && exp_rdy;
    consume = m_ov && ordy;
    is_jal  = (ins[6:0] == 7'b1101111);
    if (m_rv) begin
      if (hs) m_perf_sq++;
      if (consume) m_ov = 0;
      if (ack) m_rv = 0;
    end else if (hs) begin
      m_ov = 1; m_pc = pc; m_instr = ins; m_jal = is_jal; m_link = pc + 32'd4;
      m_mis = is_jal && jal_target(pc, ins)[1];
      if (is_jal) begin
        m_rv = 1; m_tgt = jal_target(pc, ins); m_perf_red++;
      end
    end else if (consume) begin
      m_ov = 0;
    end
    @(posedge clk); #1;
    check_outputs();
  endtask

  // Reset with busy inputs to show it overrides everything.
  task automatic do_reset();
    rst = 1; in_valid = 1; in_pc = 32'h400; in_instr = 32'h008000EF;
    out_ready = 1; redirect_ack = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    check_eq("rst_out_pc", out_pc, 0);
    check_eq("rst_out_instr", out_instr, 0);
    check_eq("rst_out_link", out_link, 0);
    check_eq("rst_out_is_jal", out_is_jal, 0);
    check_eq("rst_out_mis", out_misaligned, 0);
    check_eq("rst_redirect_target", redirect_target, 0);
    check_outputs();
  endtask

  initial begin
    rst = 1; in_valid = 0; in_pc = 0; in_instr = 0; out_ready = 0; redirect_ack = 0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Non-JAL flow
    step(1, 32'h100, 32'h0000_0013, 1, 0);
    check_eq("nonjal_pc", out_pc, 32'h100);
    check_eq("nonjal_valid", out_valid, 1);
    check_eq("nonjal_rv", redirect_valid, 0);

    // JAL forward redirect, then wrong-path squash
    step(1, 32'h1000, 32'h0080_00EF, 1, 0);
    check_eq("fwd_target", redirect_target, 32'h1008);
    check_eq("fwd_link", out_link, 32'h1004);
    check_eq("fwd_mis", out_misaligned, 0);
    check_eq("fwd_is_jal", out_is_jal, 1);
    step(1, 32'h1004, 32'h0000_0013, 1, 0);
    step(1, 32'h1008, 32'h0000_0013, 1, 0);
    step(1, 32'h100C, 32'h0080_00EF, 1, 0);
    check_eq("squash_out_valid", out_valid, 0);
    check_eq("held_rv", redirect_valid, 1);
    step(0, 32'h0, 32'h0, 1, 1);
    check_eq("ack_rv", redirect_valid, 0);
    step(1, 32'h1008, 32'h0000_0013, 1, 0);
    check_eq("postack_pc", out_pc, 32'h1008);

    // Backpressure, then consume+accept in one cycle
    step(1, 32'h2000, 32'h0000_0033, 0, 0);
    check_eq("bp_pc", out_pc, 32'h1008);
    step(1, 32'h2004, 32'h0000_0033, 1, 0);
    check_eq("ca_pc", out_pc, 32'h2004);
    check_eq("ca_valid", out_valid, 1);

    // Negative/wrap and misaligned targets
    step(1, 32'h0, 32'hFFDF_F06F, 1, 0);
    check_eq("neg_target", redirect_target, 32'hFFFF_FFFC);
    step(0, 32'h0, 32'h0, 1, 1);
    step(1, 32'h200, 32'h0020_006F, 1, 0);
    check_eq("mis_target", redirect_target, 32'h202);
    check_eq("mis_flag", out_misaligned, 1);
    step(0, 32'h0, 32'h0, 1, 1);

    // Reset mid-redirect with output held, then a stray ack
    step(1, 32'h300, 32'h0080_00EF, 0, 0);
    check_eq("pre_rst_rv", redirect_valid, 1);
    do_reset();
    step(0, 32'h0, 32'h0, 1, 1);
    check_eq("stray_ack_rv", redirect_valid, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc, ins;
      pc  = $urandom() & 32'hFFFF_FFFC;
      ins = $urandom();
      if ($urandom_range(0, 2) == 0) ins[6:0] = 7'b1101111;
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(($urandom_range(0, 3) != 0), pc, ins, ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jal_redirect_stage.md
Name: jal_redirect_stage

Overview:
- Decode-side pipeline stage that sits directly downstream of the fetch queue and upstream of the rest of decode.
- Registers each incoming instruction and its PC, and splits J-type fields internally.
- Resolves JAL targets at decode time and issues a held redirect to fetch.
- Drops wrong-path instructions until fetch acknowledges the redirect.

Parameters:
XLEN, 32, width of PC and target datapath
JAL_OPCODE, 7'b1101111, opcode value recognised as JAL

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  fetch presents instruction
in_ready  output  1  stage accepts instruction this cycle
in_pc  input  XLEN  PC of presented instruction
in_instr  input  32  presented instruction word
out_valid  output  1  registered instruction valid to decode
out_ready  input  1  decode consumes output this cycle
out_pc  output  XLEN  registered PC
out_instr  output  32  registered instruction
out_is_jal  output  1  registered instruction is JAL
out_link  output  XLEN  out_pc + 4 (JAL link value)
out_misaligned  output  1  JAL target bit[1] set (no RVC)
redirect_valid  output  1  fetch redirect request, held until ack
redirect_target  output  XLEN  out_pc + sext(imm) of the JAL
redirect_ack  input  1  fetch has taken the redirect

Behaviour:
- Reset (rst high at clk edge): state=RUN; out_valid=0, redirect_valid=0; out_pc, out_instr, out_link, redirect_target=0; out_is_jal=0, out_misaligned=0. Reset overrides all other events in the same cycle, including mid-redirect.
- Handshake: transfer on in_valid&&in_ready; output consumed on out_valid&&out_ready.
- Latency: 1 cycle from accept to out_valid.
- Output register:
  - Holds all out_* stable while out_valid&&!out_ready.
  - Clears out_valid on consume with no new accept.
  - Simultaneous consume and accept loads new data, out_valid stays 1.
- Imm decode: 21-bit {instr[31], instr[19:12], instr[20], instr[30:21], 0}, sign-extended to XLEN.
- Arithmetic: target = pc + sext(imm) modulo 2^XLEN (wrap-around, no flag). link = pc + 4 modulo 2^XLEN.
- JAL detect: is_jal = (instr[6:0]==JAL_OPCODE). Computed from input and registered alongside it.
- FSM states:
  - RUN:
    - in_ready = !out_valid || out_ready.
    - Accepted non-JAL: registered normally, state stays RUN.
    - Accepted JAL: registered with out_is_jal=1. Next cycle redirect_valid=1, redirect_target=target, out_misaligned=target[1]. Go to WAIT_ACK.
  - WAIT_ACK:
    - in_ready=1.
    - Every handshaked input is discarded (wrong path); output register is not written.
    - redirect_valid and redirect_target held stable.
    - On redirect_ack: redirect_valid=0 next cycle, return to RUN. The input handshaked in the ack cycle is also discarded.
- The pending JAL itself still flows to out_* independently of the redirect. The output may drain during WAIT_ACK.
- redirect_ack while redirect_valid=0 is ignored.
- Back-to-back JALs cannot both redirect: the second is discarded as wrong path.

Optional Feature:
- Macro: JAL_REDIRECT_PERF_EN.
- Defined:
  - Adds outputs perf_redirects[31:0] and perf_squashed[31:0], reset to 0.
  - perf_redirects increments on each RUN->WAIT_ACK transition.
  - perf_squashed increments per discarded handshake.
  - Both counters wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Non-JAL flow:
  - Stimulus: in_pc=0x100, in_instr=0x00000013 (addi), out_ready=1.
  - Response: next cycle out_valid=1, out_pc=0x100, out_is_jal=0, redirect_valid stays 0.
- JAL forward redirect:
  - Stimulus: pc=0x1000, instr=0x008000EF (jal x1,+8).
  - Response: redirect_target=0x1008, out_link=0x1004, out_misaligned=0.
  - Continue: hold redirect_ack=0 for 3 cycles, then ack. redirect_valid stays 1 throughout and drops the cycle after ack.
- Wrong-path squash:
  - Stimulus: during WAIT_ACK feed 3 instructions, pc=0x1004/0x1008/0x100C.
  - Response: in_ready=1 each cycle, none appears on out_*.
  - Continue: first post-ack instruction pc=0x1008 appears normally.
- Backpressure:
  - Stimulus: out_ready=0 with out_valid=1, in_valid=1.
  - Response: in_ready=0, out_* stable.
  - Continue: raise out_ready with new input. Response: same-cycle consume+accept, out_valid stays 1.
- Negative/wrap target:
  - Stimulus: pc=0x00000000, instr=0xFFDFF06F (jal x0,-4).
  - Response: redirect_target=0xFFFFFFFC.
  - Stimulus: imm with bit1 set (jal x0,+2, instr=0x0020006F) at pc=0x200.
  - Response: target=0x202, out_misaligned=1.
- Reset mid-redirect:
  - Stimulus: assert rst in WAIT_ACK with out_valid=1.
  - Response: next cycle redirect_valid=0, out_valid=0, state RUN; a following ack is ignored.
  - With JAL_REDIRECT_PERF_EN defined, both counters read 0 after reset.
